// File: rtl/vend_pkg.sv
// Shared vending definitions: FSM encoding, coin values and default prices
// used by the transaction controller and the other vending blocks.
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CREDIT = 2'd1,
      VEND   = 2'd2,
      CHANGE = 2'd3
   } vend_state_e;

   localparam int COIN_W           = 3;
   localparam int COIN_Q_VAL       = 1;
   localparam int COIN_D_VAL       = 4;
   localparam int PRICE_CHOC_Q_DEF = 3;
   localparam int PRICE_VAN_Q_DEF  = 2;
   localparam int MAX_CREDIT_Q_DEF = 7;
   localparam int CREDIT_W_DEF     = 3;
   localparam int TIMEOUT_CYC_DEF  = 1000;

   // A dollar wins over a simultaneous quarter; the quarter goes to the chute.
   function automatic logic [COIN_W-1:0] coin_value(input logic coin_q, input logic coin_d);
      logic [COIN_W-1:0] val;
      if (coin_d) begin
         val = COIN_W'(COIN_D_VAL);
      end else if (coin_q) begin
         val = COIN_W'(COIN_Q_VAL);
      end else begin
         val = {COIN_W{1'b0}};
      end
      return val;
   endfunction

endpackage

// File: rtl/vend_txn_controller_if.sv
// Coin, selection and dispenser/hopper handshake bundle of the vending controller.
interface vend_txn_if #(parameter int CREDIT_W = 3);
   logic                coin_q;
   logic                coin_d;
   logic                sel;
   logic                cancel;
   logic                dispense_done;
   logic                hopper_done;
   logic                dispense_req;
   logic                hopper_req;
   logic                coin_reject;
   logic [CREDIT_W-1:0] credit;
   logic                busy;

   modport master (
      output coin_q, coin_d, sel, cancel, dispense_done, hopper_done,
      input  dispense_req, hopper_req, coin_reject, credit, busy
   );

   modport slave (
      input  coin_q, coin_d, sel, cancel, dispense_done, hopper_done,
      output dispense_req, hopper_req, coin_reject, credit, busy
   );
endinterface

// File: rtl/vend_timeout_ctr.sv
// Idle-cycle counter: expire is high once the count reaches TIMEOUT_CYC-1;
// it holds there until cleared.
module vend_timeout_ctr #(
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic clock,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt_r;
   logic             expire_s;

   assign expire_s = (cnt_r == CNT_W'(TIMEOUT_CYC - 1));
   assign expire   = expire_s;

   // Count enabled cycles, saturating at the expiry value.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (clear) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (enable && !expire_s) begin
         cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end
endmodule

// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: accumulates credit, runs the dispenser
// handshake and then pays change one quarter per hopper handshake.
module vend_txn_controller
   import vend_pkg::*;
#(
   parameter int PRICE_CHOC_Q = PRICE_CHOC_Q_DEF,
   parameter int PRICE_VAN_Q  = PRICE_VAN_Q_DEF,
   parameter int MAX_CREDIT_Q = MAX_CREDIT_Q_DEF,
   parameter int CREDIT_W     = CREDIT_W_DEF,
   parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF
) (
   input  logic       clock,
   input  logic       rst,
   vend_txn_if.slave  bus
);
   localparam int SUM_W = CREDIT_W + 1;

   vend_state_e         state_r, state_nx;
   logic [CREDIT_W-1:0] credit_r, credit_nx;
   logic [CREDIT_W-1:0] change_r, change_nx;
   logic                hopper_req_r, hopper_req_nx;
   logic                coin_reject_r, coin_reject_nx;
   logic [CREDIT_W-1:0] coin_val_s;
   logic [CREDIT_W-1:0] price_s;
   logic [SUM_W-1:0]    credit_sum_s;
   logic                coin_any_s, coin_ok_s, hop_ack_s;
   logic                expire_s, tmr_clear_s, tmr_en_s;

   assign coin_any_s   = bus.coin_q | bus.coin_d;
   assign coin_val_s   = CREDIT_W'(coin_value(bus.coin_q, bus.coin_d));
   assign price_s      = bus.sel ? CREDIT_W'(PRICE_VAN_Q) : CREDIT_W'(PRICE_CHOC_Q);
   assign credit_sum_s = {1'b0, credit_r} + {1'b0, coin_val_s};

   assign tmr_en_s    = (state_r == CREDIT);
   assign tmr_clear_s = (state_r != CREDIT) | coin_ok_s;

   vend_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
      .clock  (clock),
      .rst    (rst),
      .clear  (tmr_clear_s),
      .enable (tmr_en_s),
      .expire (expire_s)
   );

   // Next-state, credit/change update and coin acceptance.
   always_comb begin
      state_nx  = state_r;
      credit_nx = credit_r;
      change_nx = change_r;
      coin_ok_s = 1'b0;
      hop_ack_s = 1'b0;
      case (state_r)
         IDLE: begin
            credit_nx = {CREDIT_W{1'b0}};
            if (coin_any_s) begin
               coin_ok_s = 1'b1;
               credit_nx = coin_val_s;
               state_nx  = CREDIT;
            end else begin
               state_nx = IDLE;
            end
         end
         CREDIT: begin
            // A coin arriving on the cycle we leave CREDIT is returned, not added.
            if (credit_r >= price_s) begin
               state_nx  = VEND;
               change_nx = credit_r - price_s;
            end else if (bus.cancel || expire_s) begin
               state_nx  = CHANGE;
               change_nx = credit_r;
            end else if (coin_any_s && (credit_sum_s <= SUM_W'(MAX_CREDIT_Q))) begin
               coin_ok_s = 1'b1;
               credit_nx = credit_sum_s[CREDIT_W-1:0];
            end else begin
               state_nx = CREDIT;
            end
         end
         VEND: begin
            if (bus.dispense_done) begin
               credit_nx = {CREDIT_W{1'b0}};
               state_nx  = (change_r != {CREDIT_W{1'b0}}) ? CHANGE : IDLE;
            end else begin
               state_nx = VEND;
            end
         end
         CHANGE: begin
            if (change_r == {CREDIT_W{1'b0}}) begin
               state_nx  = IDLE;
               credit_nx = {CREDIT_W{1'b0}};
            end else if (bus.hopper_done && hopper_req_r) begin
               hop_ack_s = 1'b1;
               change_nx = change_r - {{(CREDIT_W-1){1'b0}}, 1'b1};
            end else begin
               state_nx = CHANGE;
            end
         end
         default: begin
            state_nx  = IDLE;
            credit_nx = {CREDIT_W{1'b0}};
            change_nx = {CREDIT_W{1'b0}};
         end
      endcase

      coin_reject_nx = (bus.coin_q & bus.coin_d) | (coin_any_s & ~coin_ok_s);
      // Dropping the request for the ack cycle gives each quarter a fresh request.
      hopper_req_nx  = (state_nx == CHANGE) & (change_nx != {CREDIT_W{1'b0}}) & ~hop_ack_s;
   end

   // State, counters and registered outputs.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_r       <= IDLE;
         credit_r      <= {CREDIT_W{1'b0}};
         change_r      <= {CREDIT_W{1'b0}};
         hopper_req_r  <= 1'b0;
         coin_reject_r <= 1'b0;
      end else begin
         state_r       <= state_nx;
         credit_r      <= credit_nx;
         change_r      <= change_nx;
         hopper_req_r  <= hopper_req_nx;
         coin_reject_r <= coin_reject_nx;
      end
   end

   assign bus.dispense_req = (state_r == VEND);
   assign bus.busy         = (state_r == VEND) | (state_r == CHANGE);
   assign bus.hopper_req   = hopper_req_r;
   assign bus.coin_reject  = coin_reject_r;
   assign bus.credit       = credit_r;
endmodule
